// File: rtl/dma_bus_master_pkg.sv
// Shared definitions for the 6809 DMA bus master: state encoding and
// default burst/pause budgets.
package dma_bus_master_pkg;

  localparam int unsigned BURST_MAX_DEF = 14;
  localparam int unsigned PAUSE_E_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_GRANT,
    ST_ADDR,
    ST_DATA,
    ST_PAUSE,
    ST_DONE
  } state_e;

  // States in which the 6809 is asked to hold off (o_DMA low).
  function automatic logic holds_bus(state_e s);
    return (s == ST_REQ) || (s == ST_WAIT_GRANT) || (s == ST_ADDR) || (s == ST_DATA);
  endfunction

  function automatic logic drives_bus(state_e s);
    return (s == ST_ADDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/dma_bus_master_e_edge_sync.sv
// Brings the 6809 E, BA and BS signals into the clk domain and derives
// single-clk E-rise / E-fall strobes plus the bus-grant condition.
module e_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_E,
  input  logic i_BA,
  input  logic i_BS,
  output logic o_e_rise,
  output logic o_e_fall,
  output logic o_grant
);

  logic e_meta_q, e_meta_d;
  logic e_sync_q, e_sync_d;
  logic e_prev_q, e_prev_d;
  logic ba_meta_q, ba_meta_d;
  logic ba_sync_q, ba_sync_d;
  logic bs_meta_q, bs_meta_d;
  logic bs_sync_q, bs_sync_d;

  always_comb begin
    e_meta_d  = i_E;
    e_sync_d  = e_meta_q;
    e_prev_d  = e_sync_q;
    ba_meta_d = i_BA;
    ba_sync_d = ba_meta_q;
    bs_meta_d = i_BS;
    bs_sync_d = bs_meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_meta_q  <= 1'b0;
      e_sync_q  <= 1'b0;
      e_prev_q  <= 1'b0;
      ba_meta_q <= 1'b0;
      ba_sync_q <= 1'b0;
      bs_meta_q <= 1'b0;
      bs_sync_q <= 1'b0;
    end else begin
      e_meta_q  <= e_meta_d;
      e_sync_q  <= e_sync_d;
      e_prev_q  <= e_prev_d;
      ba_meta_q <= ba_meta_d;
      ba_sync_q <= ba_sync_d;
      bs_meta_q <= bs_meta_d;
      bs_sync_q <= bs_sync_d;
    end
  end

  assign o_e_rise = e_sync_q & ~e_prev_q;
  assign o_e_fall = ~e_sync_q & e_prev_q;
  assign o_grant  = ba_sync_q & bs_sync_q;

endmodule

// File: rtl/dma_bus_master.sv
// 6809 DMA bus master: requests the bus via o_DMA, then writes a block of
// source bytes to consecutive addresses in bursts bounded by BURST_MAX.
module dma_bus_master
  import dma_bus_master_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEF,
  parameter int unsigned PAUSE_E   = PAUSE_E_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [15:0] i_base_addr,
  input  logic [8:0]  i_count,
  input  logic [7:0]  i_wdata,
  input  logic        i_wvalid,
  output logic        o_wready,
  input  logic        i_E,
  input  logic        i_BA,
  input  logic        i_BS,
  output logic        o_DMA,
  output logic [15:0] o_ADDR,
  output logic        o_ADDR_OE,
  output logic [7:0]  o_DATA,
  output logic        o_DATA_OE,
  output logic        o_RW,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned BW = $clog2(BURST_MAX + 2);
  localparam int unsigned PW = (PAUSE_E > 1) ? $clog2(PAUSE_E) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_E - 1);

  logic e_rise, e_fall, grant;

  e_edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .i_E      (i_E),
    .i_BA     (i_BA),
    .i_BS     (i_BS),
    .o_e_rise (e_rise),
    .o_e_fall (e_fall),
    .o_grant  (grant)
  );

  state_e          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [8:0]      remain_q, remain_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [BW-1:0]   burst_inc;
  logic [PW-1:0]   pause_q, pause_d;
  logic [7:0]      data_q, data_d;
  logic            dma_q, dma_d;
  logic            addr_oe_q, addr_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            rw_q, rw_d;
  logic            wready_q, wready_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  assign burst_inc = burst_q + BW'(1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    burst_d  = burst_q;
    pause_d  = pause_q;
    data_d   = data_q;
    wready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d   = i_base_addr;
          remain_d = i_count;
          state_d  = (i_count == 9'd0) ? ST_DONE : ST_REQ;
        end
      end

      ST_REQ: begin
        burst_d = '0;
        state_d = ST_WAIT_GRANT;
      end

      // An E cycle that starts granted but without source data is left
      // undriven yet still charged against the burst budget.
      ST_WAIT_GRANT: begin
        if (e_fall && grant) begin
          if (burst_q == BURST_LAST) begin
            pause_d = '0;
            state_d = ST_PAUSE;
          end else if (i_wvalid) begin
            data_d  = i_wdata;
            state_d = ST_ADDR;
          end else begin
            burst_d = burst_inc;
          end
        end
      end

      // The source only advances after the o_wready pulse, so a
      // back-to-back launch refreshes the byte during the address phase.
      ST_ADDR: begin
        if (!grant) begin
          state_d = ST_REQ;
        end else begin
          if (i_wvalid) data_d = i_wdata;
          if (e_rise) state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!grant) begin
          state_d = ST_REQ;
        end else if (e_fall) begin
          wready_d = 1'b1;
          addr_d   = addr_q + 16'd1;
          remain_d = remain_q - 9'd1;
          burst_d  = burst_inc;
          if (remain_q == 9'd1) begin
            state_d = ST_DONE;
          end else if (burst_inc == BURST_LAST) begin
            pause_d = '0;
            state_d = ST_PAUSE;
          end else if (i_wvalid) begin
            data_d  = i_wdata;
            state_d = ST_ADDR;
          end else begin
            burst_d = burst_inc + BW'(1);
            state_d = ST_WAIT_GRANT;
          end
        end
      end

      ST_PAUSE: begin
        if (e_fall) begin
          if (pause_q == PAUSE_LAST) state_d = ST_REQ;
          else                       pause_d = pause_q + PW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus-facing outputs are registered from the next state so they
    // change on the same edge as the state register.
    dma_d     = ~holds_bus(state_d);
    addr_oe_d = drives_bus(state_d);
    data_oe_d = (state_d == ST_DATA);
    rw_d      = ~drives_bus(state_d);
    done_d    = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      burst_q   <= '0;
      pause_q   <= '0;
      data_q    <= '0;
      dma_q     <= 1'b1;
      addr_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      rw_q      <= 1'b1;
      wready_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      burst_q   <= burst_d;
      pause_q   <= pause_d;
      data_q    <= data_d;
      dma_q     <= dma_d;
      addr_oe_q <= addr_oe_d;
      data_oe_q <= data_oe_d;
      rw_q      <= rw_d;
      wready_q  <= wready_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign o_DMA     = dma_q;
  assign o_ADDR    = addr_q;
  assign o_ADDR_OE = addr_oe_q;
  assign o_DATA    = data_q;
  assign o_DATA_OE = data_oe_q;
  assign o_RW      = rw_q;
  assign o_wready  = wready_q;
  assign o_done    = done_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master: logs every bus write cycle and compares
// against hand-computed addresses, data, pulse counts and pause lengths.
module tb_dma_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_base_addr = '0;
  logic [8:0]  i_count = '0;
  logic [7:0]  i_wdata;
  logic        i_wvalid;
  logic        o_wready;
  logic        i_E;
  logic        i_BA;
  logic        i_BS;
  logic        o_DMA;
  logic [15:0] o_ADDR;
  logic        o_ADDR_OE;
  logic [7:0]  o_DATA;
  logic        o_DATA_OE;
  logic        o_RW;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int failures = 0;

  // Grant stimulus: constant, killed, or auto-granted one E after a request.
  logic gnt_const = 1'b0;
  logic gnt_kill  = 1'b0;
  logic gnt_auto  = 1'b0;
  logic ba_auto;

  assign i_BA = !gnt_kill && (gnt_const || ba_auto);
  assign i_BS = i_BA;

  // Source: bytes A0, A1, ... advancing on each o_wready.
  logic [7:0] src_idx = '0;
  assign i_wdata  = 8'hA0 + src_idx;
  assign i_wvalid = 1'b1;

  dma_bus_master #(.BURST_MAX(14), .PAUSE_E(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_count     (i_count),
    .i_wdata     (i_wdata),
    .i_wvalid    (i_wvalid),
    .o_wready    (o_wready),
    .i_E         (i_E),
    .i_BA        (i_BA),
    .i_BS        (i_BS),
    .o_DMA       (o_DMA),
    .o_ADDR      (o_ADDR),
    .o_ADDR_OE   (o_ADDR_OE),
    .o_DATA      (o_DATA),
    .o_DATA_OE   (o_DATA_OE),
    .o_RW        (o_RW),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // E period = 8 clks, phase offset so edges never coincide with clk edges.
  initial begin
    i_E = 1'b0;
    #3;
    forever #40 i_E = ~i_E;
  end

  initial begin
    ba_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (!gnt_auto) ba_auto = 1'b0;
      else if (!o_DMA && !ba_auto) begin
        @(negedge i_E);
        ba_auto = 1'b1;
      end else if (o_DMA) ba_auto = 1'b0;
    end
  end

  // Bus monitor
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic        log_rw[$];
  int          run_len[$];
  int          run_logsz[$];
  logic        data_oe_prev = 1'b0;
  int          wready_cnt = 0;
  int          done_cnt = 0;
  int          dma_low_clks = 0;
  int          run = 0;

  always @(negedge clk) begin
    data_oe_prev <= o_DATA_OE;
    if (o_DATA_OE && !data_oe_prev) begin
      log_addr.push_back(o_ADDR);
      log_data.push_back(o_DATA);
      log_rw.push_back(o_RW);
    end
    if (o_wready) begin
      wready_cnt <= wready_cnt + 1;
      src_idx    <= src_idx + 8'd1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (!o_DMA) dma_low_clks <= dma_low_clks + 1;
    if (o_busy && o_DMA) begin
      if (run == 0) run_logsz.push_back(log_addr.size());
      run <= run + 1;
    end else if (run != 0) begin
      run_len.push_back(run);
      run <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_xfer(input logic [15:0] b, input logic [8:0] c);
    @(posedge clk); #1;
    i_base_addr = b;
    i_count     = c;
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!o_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(o_done), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  int          l0, w0, d0, r0, k0, n;
  logic [7:0]  src0;
  logic [15:0] exp_addr[5];
  logic [7:0]  exp_off[5];

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_dma",     32'(o_DMA), 32'd1);
    check_eq("rst_rw",      32'(o_RW), 32'd1);
    check_eq("rst_addr_oe", 32'(o_ADDR_OE), 32'd0);
    check_eq("rst_data_oe", 32'(o_DATA_OE), 32'd0);
    check_eq("rst_busy",    32'(o_busy), 32'd0);
    check_eq("rst_wready",  32'(o_wready), 32'd0);
    check_eq("rst_done",    32'(o_done), 32'd0);
    check_eq("rst_addr",    32'(o_ADDR), 32'd0);
    check_eq("rst_data",    32'(o_DATA), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // S1: base 0x0100, count 3, grant one E after the request
    gnt_auto = 1'b1;
    l0 = log_addr.size(); w0 = wready_cnt; d0 = done_cnt; src0 = src_idx;
    start_xfer(16'h0100, 9'd3);
    wait_done("s1", 2000);
    check_eq("s1_nwrites", 32'(log_addr.size() - l0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("s1_addr%0d", k), 32'(log_addr[l0+k]), 32'(16'h0100 + 16'(k)));
      check_eq($sformatf("s1_data%0d", k), 32'(log_data[l0+k]), 32'(8'(8'hA0 + src0 + 8'(k))));
      check_eq($sformatf("s1_rw%0d", k),   32'(log_rw[l0+k]), 32'd0);
    end
    check_eq("s1_wready", 32'(wready_cnt - w0), 32'd3);
    check_eq("s1_done",   32'(done_cnt - d0), 32'd1);
    check_eq("s1_dma_after", 32'(o_DMA), 32'd1);
    check_eq("s1_busy_after", 32'(o_busy), 32'd0);
    gnt_auto = 1'b0;
    repeat (4) @(negedge clk);

    // S2: count 20 with constant grant: 14, pause of 2 E (16 clks), 6
    gnt_const = 1'b1;
    l0 = log_addr.size(); w0 = wready_cnt; d0 = done_cnt; r0 = run_len.size(); k0 = run_logsz.size();
    start_xfer(16'h1000, 9'd20);
    wait_done("s2", 3000);
    check_eq("s2_nwrites", 32'(log_addr.size() - l0), 32'd20);
    check_eq("s2_runs", 32'(run_len.size() - r0), 32'd2);
    check_eq("s2_pause_len", 32'(run_len[r0]), 32'd16);
    check_eq("s2_done_len", 32'(run_len[r0+1]), 32'd1);
    check_eq("s2_burst1", 32'(run_logsz[k0] - l0), 32'd14);
    check_eq("s2_burst2", 32'(run_logsz[k0+1] - l0), 32'd20);
    check_eq("s2_addr_first", 32'(log_addr[l0]), 32'h1000);
    check_eq("s2_addr_after_pause", 32'(log_addr[l0+14]), 32'h100E);
    check_eq("s2_addr_last", 32'(log_addr[l0+19]), 32'h1013);
    check_eq("s2_wready", 32'(wready_cnt - w0), 32'd20);
    check_eq("s2_done", 32'(done_cnt - d0), 32'd1);

    // S3: address wrap
    l0 = log_addr.size(); w0 = wready_cnt;
    start_xfer(16'hFFFF, 9'd2);
    wait_done("s3", 2000);
    check_eq("s3_nwrites", 32'(log_addr.size() - l0), 32'd2);
    check_eq("s3_addr0", 32'(log_addr[l0]), 32'hFFFF);
    check_eq("s3_addr1", 32'(log_addr[l0+1]), 32'h0000);
    check_eq("s3_wready", 32'(wready_cnt - w0), 32'd2);
    gnt_const = 1'b0;
    repeat (4) @(negedge clk);

    // S4: count 0 -> immediate done, no bus request
    n = dma_low_clks; d0 = done_cnt;
    start_xfer(16'h4000, 9'd0);
    check_eq("s4_done_now", 32'(o_done), 32'd1);
    @(posedge clk); #1;
    check_eq("s4_done_pulse_end", 32'(o_done), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("s4_dma_never_low", 32'(dma_low_clks - n), 32'd0);
    check_eq("s4_done_once", 32'(done_cnt - d0), 32'd1);

    // S5: grant lost during DATA of byte 2 of 4
    gnt_const = 1'b1;
    l0 = log_addr.size(); w0 = wready_cnt; src0 = src_idx;
    start_xfer(16'h0200, 9'd4);
    n = 0;
    while (!(wready_cnt - w0 == 1 && o_DATA_OE) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("s5_reach_byte2_data", 32'(n < 500), 32'd1);
    gnt_kill = 1'b1;
    n = 0;
    while ((o_ADDR_OE || o_DATA_OE) && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("s5_oe_clear_fast", 32'(n <= 3), 32'd1);
    check_eq("s5_byte2_unconsumed", 32'(wready_cnt - w0), 32'd1);
    repeat (16) @(negedge clk);
    gnt_kill = 1'b0;
    wait_done("s5", 2000);
    exp_addr = '{16'h0200, 16'h0201, 16'h0201, 16'h0202, 16'h0203};
    exp_off  = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    check_eq("s5_nwrites", 32'(log_addr.size() - l0), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("s5_addr%0d", k), 32'(log_addr[l0+k]), 32'(exp_addr[k]));
      check_eq($sformatf("s5_data%0d", k), 32'(log_data[l0+k]), 32'(8'(8'hA0 + src0 + exp_off[k])));
    end
    check_eq("s5_wready", 32'(wready_cnt - w0), 32'd4);

    // S6: asynchronous reset while in ADDR
    w0 = wready_cnt; d0 = done_cnt;
    start_xfer(16'h0300, 9'd3);
    n = 0;
    while (!(o_ADDR_OE && !o_DATA_OE) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("s6_reach_addr", 32'(n < 500), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("s6_addr_oe", 32'(o_ADDR_OE), 32'd0);
    check_eq("s6_data_oe", 32'(o_DATA_OE), 32'd0);
    check_eq("s6_dma", 32'(o_DMA), 32'd1);
    check_eq("s6_busy", 32'(o_busy), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("s6_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("s6_no_wready", 32'(wready_cnt - w0), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("s6_idle_after", 32'(o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
